// File: rtl/edge_event_array.sv
// edge_event_array: multi-channel edge-event detector.
//
// Each channel synchronises an asynchronous level input, applies a
// consecutive-cycle stability filter, and emits registered one-cycle
// rising, falling and mode-qualified event pulses. Channels are fully
// independent and share only the clock and reset.
//
// Optional feature, selected by the macro EDGE_EVENT_STICKY_EN:
//   defined     - a per-channel sticky pending flag is set by each event
//                 pulse and cleared by clr_in (a set wins over a clear).
//   not defined - pend_out is tied to 0, clr_in is ignored, and no
//                 pending flops are built.
// The port list is the same in both builds.
//
// Latency: if the first clk_in edge that samples a new stable edge_in value
// is edge 1, the accepted level and its pulses become visible after edge
// SYNC+FILT-1. The filter's own level register acts as the last
// synchroniser stage, so only SYNC-1 dedicated flops sit in front of it.

module edge_event_array #(
  parameter int CH   = 4,  // number of independent channels, >= 1
  parameter int SYNC = 2,  // synchroniser depth in flops, >= 1
  parameter int FILT = 4   // cycles a new level must persist, >= 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [CH-1:0]   edge_in,
  input  logic [2*CH-1:0] mode_in,
  input  logic [CH-1:0]   clr_in,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   rising_out,
  output logic [CH-1:0]   falling_out,
  output logic [CH-1:0]   event_out,
  output logic            event_any_out,
  output logic [CH-1:0]   pend_out
);

  // Filter counter width; it only ever needs to reach FILT-1.
  localparam int CW = $clog2(FILT + 1);

  // Reject unusable configurations while elaborating.
  if (CH < 1) begin : g_bad_ch
    $error("edge_event_array: CH must be >= 1");
  end
  if (SYNC < 1) begin : g_bad_sync
    $error("edge_event_array: SYNC must be >= 1");
  end
  if (FILT < 1) begin : g_bad_filt
    $error("edge_event_array: FILT must be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          filt_in;  // synchronised level seen by the filter
    logic          lvl_q;    // accepted (filtered) level
    logic [CW-1:0] cnt_q;    // cycles the new level has persisted so far
    logic [CW-1:0] cnt_d;
    logic          lvl_d;
    logic          accept;   // new level accepted at this edge
    logic          rise_d;
    logic          fall_d;
    logic          evt_d;
    logic          rise_q;
    logic          fall_q;
    logic          evt_q;

    if (SYNC > 1) begin : g_sync
      logic [SYNC-2:0] sync_q;

      // Shift the raw level through the dedicated synchroniser flops.
      always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state is written with <= so every flop samples
        // the pre-edge values of its neighbours; blocking = here would
        // collapse the chain into a single stage.
        if (rst_in) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= edge_in[i];
          for (int k = 1; k < SYNC - 1; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign filt_in = sync_q[SYNC-2];
    end else begin : g_nosync
      // Single-stage configuration: the filter registers are the only
      // synchroniser stage.
      assign filt_in = edge_in[i];
    end

    // Stability filter: count consecutive cycles that disagree with the
    // accepted level, and accept the new level once it has held FILT cycles.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      accept = 1'b0;
      cnt_d  = '0;
      lvl_d  = lvl_q;
      if (filt_in != lvl_q) begin
        if (cnt_q == CW'(FILT - 1)) begin
          accept = 1'b1;
          lvl_d  = filt_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Pulse qualification: rising/falling are mode-independent, the event
    // pulse uses mode_in as sampled at the accept edge.
    always_comb begin
      rise_d = accept & filt_in;
      fall_d = accept & ~filt_in;
      evt_d  = (rise_d & mode_in[2*i]) | (fall_d & mode_in[2*i+1]);
    end

    // Filter state and one-cycle pulse registers; the pulse registers load
    // on every clock so each pulse lasts exactly one cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        lvl_q  <= 1'b0;
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        evt_q  <= 1'b0;
      end else begin
        lvl_q  <= lvl_d;
        cnt_q  <= cnt_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        evt_q  <= evt_d;
      end
    end

    assign level_out[i]   = lvl_q;
    assign rising_out[i]  = rise_q;
    assign falling_out[i] = fall_q;
    assign event_out[i]   = evt_q;

`ifdef EDGE_EVENT_STICKY_EN
    logic pend_q;

    // Sticky pending flag: set by the same edge that raises event_out, a
    // simultaneous clear loses so no event is ever dropped.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= evt_d | (pend_q & ~clr_in[i]);
      end
    end

    assign pend_out[i] = pend_q;
`else
    assign pend_out[i] = 1'b0;
`endif
  end

`ifdef EDGE_EVENT_STICKY_EN
`else
  // clr_in has no function without pending flags; fold it into a net that
  // is intentionally left without a load.
  logic unused_clr;
  assign unused_clr = ^clr_in;
`endif

  // Any-event summary, combinational from the event registers so it is
  // valid in the same cycle as event_out.
  assign event_any_out = |event_out;

endmodule

// File: tb/tb_edge_event_array.sv
// tb_edge_event_array: scoreboard bench for edge_event_array.
// Stimulus code pushes the expected value of one output for a given cycle
// when it drives the inputs; each falling clock edge pops and compares the
// entries due in that cycle. A second, minimal instance (CH=1, SYNC=1,
// FILT=1) covers the single-stage latency with edge_in high across reset.

module tb_edge_event_array;

  localparam int CH = 4;

  typedef enum int {
    S_LVL, S_RISE, S_FALL, S_EVT, S_ANY, S_PEND, S_LVL1, S_RISE1, S_FALL1
  } sig_e;

  typedef struct {
    string       tag;
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [CH-1:0]   edge_in;
  logic [2*CH-1:0] mode_in;
  logic [CH-1:0]   clr_in;
  logic [CH-1:0]   level_out;
  logic [CH-1:0]   rising_out;
  logic [CH-1:0]   falling_out;
  logic [CH-1:0]   event_out;
  logic            event_any_out;
  logic [CH-1:0]   pend_out;

  logic rst1 = 1'b1;
  logic edge1;
  logic lvl1, rise1, fall1, evt1, any1, pend1;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  edge_event_array #(.CH(CH), .SYNC(2), .FILT(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .edge_in       (edge_in),
    .mode_in       (mode_in),
    .clr_in        (clr_in),
    .level_out     (level_out),
    .rising_out    (rising_out),
    .falling_out   (falling_out),
    .event_out     (event_out),
    .event_any_out (event_any_out),
    .pend_out      (pend_out)
  );

  edge_event_array #(.CH(1), .SYNC(1), .FILT(1)) dut_min (
    .clk_in        (clk_in),
    .rst_in        (rst1),
    .edge_in       (edge1),
    .mode_in       (2'b01),
    .clr_in        (1'b0),
    .level_out     (lvl1),
    .rising_out    (rise1),
    .falling_out   (fall1),
    .event_out     (evt1),
    .event_any_out (any1),
    .pend_out      (pend1)
  );

  always #5 clk_in = ~clk_in;

  // Cycle index: after posedge number k, cyc == k.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_LVL:   return 32'(level_out);
      S_RISE:  return 32'(rising_out);
      S_FALL:  return 32'(falling_out);
      S_EVT:   return 32'(event_out);
      S_ANY:   return 32'(event_any_out);
      S_PEND:  return 32'(pend_out);
      S_LVL1:  return 32'(lvl1);
      S_RISE1: return 32'(rise1);
      default: return 32'(fall1);
    endcase
  endfunction

  // Expected pending flags: only the sticky build ever raises them.
  function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef EDGE_EVENT_STICKY_EN
    return v;
`else
    return 32'(v & 32'h0);
`endif
  endfunction

  // Queue an expectation for the negedge dc cycles from now.
  task automatic exp_at(input string tag, input int dc, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc + dc;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_zero(input string tag, input int dc);
    exp_at(tag, dc, S_LVL, 0);
    exp_at(tag, dc, S_RISE, 0);
    exp_at(tag, dc, S_FALL, 0);
    exp_at(tag, dc, S_EVT, 0);
    exp_at(tag, dc, S_ANY, 0);
    exp_at(tag, dc, S_PEND, 0);
  endtask

  // Advance to the next falling edge and compare every entry due there.
  task automatic tick();
    @(negedge clk_in);
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        check($sformatf("%s.%s", sb[k].tag, sb[k].sig.name()), observe(sb[k].sig), sb[k].val);
        sb.delete(k);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    edge_in = '0;
    mode_in = 8'b11_10_11_01;  // ch3 both, ch2 falling, ch1 both, ch0 rising
    clr_in  = '0;
    edge1   = 1'b1;            // held high through the minimal instance's reset

    // Reset state.
    ticks(2);
    exp_zero("reset", 1);
    exp_at("reset", 1, S_LVL1, 0);
    exp_at("reset", 1, S_RISE1, 0);
    tick();
    rst_in = 1'b0;
    ticks(3);

    // ch0 (mode 01) rises and holds: visible after edge 5, not before.
    edge_in[0] = 1'b1;
    exp_at("ch0_early", 4, S_LVL, 4'b0000);
    exp_at("ch0_early", 4, S_RISE, 4'b0000);
    exp_at("ch0_rise", 5, S_LVL, 4'b0001);
    exp_at("ch0_rise", 5, S_RISE, 4'b0001);
    exp_at("ch0_rise", 5, S_FALL, 4'b0000);
    exp_at("ch0_rise", 5, S_EVT, 4'b0001);
    exp_at("ch0_rise", 5, S_ANY, 1);
    exp_at("ch0_rise", 5, S_PEND, pexp(4'b0001));
    exp_at("ch0_after", 6, S_LVL, 4'b0001);
    exp_at("ch0_after", 6, S_RISE, 4'b0000);
    exp_at("ch0_after", 6, S_EVT, 4'b0000);
    exp_at("ch0_after", 6, S_ANY, 0);
    ticks(10);

    // ch1 glitch of 3 clocks: filtered out completely.
    edge_in[1] = 1'b1;
    exp_at("ch1_glitch", 5, S_LVL, 4'b0001);
    exp_at("ch1_glitch", 5, S_RISE, 4'b0000);
    exp_at("ch1_glitch", 7, S_LVL, 4'b0001);
    exp_at("ch1_glitch", 9, S_FALL, 4'b0000);
    ticks(3);
    edge_in[1] = 1'b0;
    ticks(9);

    // ch1 pulse of 6 clocks: rising pulse, then falling pulse 6 cycles later.
    edge_in[1] = 1'b1;
    exp_at("ch1_rise", 5, S_LVL, 4'b0011);
    exp_at("ch1_rise", 5, S_RISE, 4'b0010);
    exp_at("ch1_rise", 5, S_EVT, 4'b0010);
    exp_at("ch1_rise_end", 6, S_RISE, 4'b0000);
    exp_at("ch1_fall", 11, S_LVL, 4'b0001);
    exp_at("ch1_fall", 11, S_FALL, 4'b0010);
    exp_at("ch1_fall", 11, S_EVT, 4'b0010);
    exp_at("ch1_fall", 11, S_ANY, 1);
    exp_at("ch1_fall_end", 12, S_FALL, 4'b0000);
    ticks(6);
    edge_in[1] = 1'b0;
    ticks(10);

    // ch1 toggling every cycle: never accepted.
    for (int t = 0; t < 12; t++) begin
      edge_in[1] = ~edge_in[1];
      exp_at("ch1_toggle", 3, S_LVL, 4'b0001);
      exp_at("ch1_toggle", 3, S_RISE, 4'b0000);
      tick();
    end
    edge_in[1] = 1'b0;
    ticks(6);

    // ch2 (mode 10): rising gives no event, falling does.
    edge_in[2] = 1'b1;
    exp_at("ch2_rise", 5, S_LVL, 4'b0101);
    exp_at("ch2_rise", 5, S_RISE, 4'b0100);
    exp_at("ch2_rise", 5, S_EVT, 4'b0000);
    exp_at("ch2_rise", 5, S_ANY, 0);
    ticks(8);
    edge_in[2] = 1'b0;
    exp_at("ch2_fall", 5, S_LVL, 4'b0001);
    exp_at("ch2_fall", 5, S_FALL, 4'b0100);
    exp_at("ch2_fall", 5, S_EVT, 4'b0100);
    exp_at("ch2_fall", 5, S_ANY, 1);
    exp_at("ch2_fall_end", 6, S_FALL, 4'b0000);
    exp_at("ch2_fall_end", 6, S_EVT, 4'b0000);
    ticks(8);

    // Pending flags accumulated by ch0, ch1 and ch2 events, then cleared.
    exp_at("pend_hold", 1, S_PEND, pexp(4'b0111));
    tick();
    clr_in = '1;
    exp_at("pend_clr_all", 1, S_PEND, 0);
    tick();
    clr_in = '0;
    tick();

    // ch3 (mode 11): sticky set, set-beats-clear, lone clear.
    edge_in[3] = 1'b1;
    exp_at("ch3_rise", 5, S_RISE, 4'b1000);
    exp_at("ch3_rise", 5, S_EVT, 4'b1000);
    exp_at("ch3_rise", 5, S_PEND, pexp(4'b1000));
    exp_at("ch3_pend_hold", 8, S_PEND, pexp(4'b1000));
    ticks(8);
    edge_in[3] = 1'b0;
    exp_at("ch3_fall", 5, S_FALL, 4'b1000);
    exp_at("ch3_fall", 5, S_EVT, 4'b1000);
    exp_at("ch3_set_vs_clr", 5, S_PEND, pexp(4'b1000));
    exp_at("ch3_set_vs_clr", 6, S_PEND, pexp(4'b1000));
    ticks(4);
    clr_in[3] = 1'b1;  // sampled on the same edge as the falling event
    tick();
    clr_in[3] = 1'b0;
    tick();
    clr_in[3] = 1'b1;  // lone clear
    exp_at("ch3_lone_clr", 1, S_PEND, 0);
    tick();
    clr_in[3] = 1'b0;
    ticks(3);

    // Reset pulsed while ch0's filter is counting toward a fall (cnt == 2).
    edge_in[0] = 1'b0;
    exp_at("rst_pre", 2, S_LVL, 4'b0001);
    ticks(2);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    exp_zero("rst_async", 0);
    tick();
    tick();
    rst_in = 1'b0;
    for (int d = 2; d <= 8; d += 3) begin
      exp_at("rst_release", d, S_LVL, 0);
      exp_at("rst_release", d, S_RISE, 0);
      exp_at("rst_release", d, S_FALL, 0);
    end
    ticks(9);

    // Minimal instance: edge_in high across release, pulse after edge 1.
    rst1 = 1'b0;
    exp_at("min_rise", 1, S_LVL1, 1);
    exp_at("min_rise", 1, S_RISE1, 1);
    exp_at("min_rise_end", 2, S_LVL1, 1);
    exp_at("min_rise_end", 2, S_RISE1, 0);
    ticks(3);
    edge1 = 1'b0;
    exp_at("min_fall", 1, S_LVL1, 0);
    exp_at("min_fall", 1, S_FALL1, 1);
    exp_at("min_fall_end", 2, S_FALL1, 0);
    ticks(3);

    // Every queued expectation must have been reached.
    check("sb_drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
